chan_mux_seq: RTL and testbench

Parametrised, registered N-channel W-bit selector with a direct-select mode and an auto-scan mode. In direct mode it replaces the fixed 6-way 4-bit combinational multiplexer. In scan mode an internal scan counter steps through every channel with a programmable dwell time. It sits between the channel data sources and the display/output stage. Out-of-range selects produce zero, and the output is always registered.

---
 rtl/chan_mux_pkg.sv | 19 +
 rtl/chan_scan_ctr.sv | 47 ++++
 rtl/chan_mux_seq.sv | 106 ++++++++++
 tb/tb_chan_mux_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/chan_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chan_mux_pkg : shared types and defaults for the channel selector     |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package chan_mux_pkg;
  typedef enum logic [0:0] {
    DIRECT = 1'b0,
    SCAN   = 1'b1
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int CH_DEFAULT      = 6;
  localparam int W_DEFAULT       = 4;
  localparam int DWELL_W_DEFAULT = 8;
endpackage
`default_nettype wire

// File: rtl/chan_scan_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chan_scan_ctr : scan pointer with programmable dwell per channel      |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module chan_scan_ctr
  import chan_mux_pkg::*;
#(
  parameter  int CH      = CH_DEFAULT,
  parameter  int DWELL_W = DWELL_W_DEFAULT,
  localparam int SW      = $clog2(CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SW-1:0]      ptr,
  output logic               wrap_next
);
  localparam logic [SW-1:0] C_LAST = SW'(CH - 1);

  logic [DWELL_W-1:0] r_cnt;

  // >= rather than == so a dwell lowered below the live count advances at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      r_cnt     <= '0;
      wrap_next <= 1'b0;
    end else if (clear) begin
      ptr       <= '0;
      r_cnt     <= '0;
      wrap_next <= 1'b0;
    end else if (step) begin
      if (r_cnt >= dwell) begin
        r_cnt     <= '0;
        wrap_next <= (ptr == C_LAST);
        ptr       <= (ptr == C_LAST) ? '0 : ptr + 1'b1;
      end else begin
        r_cnt     <= r_cnt + 1'b1;
        wrap_next <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/chan_mux_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chan_mux_seq : registered N-channel selector, direct or auto-scan     |
// | scan mode present only when CHAN_MUX_SCAN_EN is defined. rev 1.0      |
// +----------------------------------------------------------------------+
module chan_mux_seq
  import chan_mux_pkg::*;
#(
  parameter  int CH      = CH_DEFAULT,
  parameter  int W       = W_DEFAULT,
  parameter  int DWELL_W = DWELL_W_DEFAULT,
  localparam int SW      = $clog2(CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SW-1:0]      sel,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [CH*W-1:0]    data,
  output logic [W-1:0]       out,
  output logic               out_valid,
  output logic [SW-1:0]      cur_ch,
  output logic               wrap
);
  state_t        r_state;
  logic [SW-1:0] w_ptr;
  logic          w_wrap_next;
  logic          w_scan_active;
  logic          w_sel_ok;
  logic [W-1:0]  w_sel_data;
  logic [W-1:0]  w_ptr_data;

`ifdef CHAN_MUX_SCAN_EN
  assign w_scan_active = (r_state == SCAN) && (mode == MODE_SCAN);

  chan_scan_ctr #(
    .CH      (CH),
    .DWELL_W (DWELL_W)
  ) u_scan_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (r_state != SCAN),
    .step      (en && w_scan_active),
    .dwell     (dwell),
    .ptr       (w_ptr),
    .wrap_next (w_wrap_next)
  );

  // wrap lines up with the first registered sample of channel 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap <= 1'b0;
    else        wrap <= en && w_scan_active && w_wrap_next;
  end
`else
  logic w_unused_dwell;
  assign w_unused_dwell = ^dwell;
  assign w_scan_active  = 1'b0;
  assign w_ptr          = '0;
  assign w_wrap_next    = 1'b0;
  assign wrap           = w_wrap_next;
`endif

  always_comb begin
    w_sel_data = '0;
    w_ptr_data = '0;
    for (int k = 0; k < CH; k++) begin
      if (sel == SW'(k))   w_sel_data = data[k*W +: W];
      if (w_ptr == SW'(k)) w_ptr_data = data[k*W +: W];
    end
  end

  assign w_sel_ok = (32'(sel) < CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= DIRECT;
      out       <= '0;
      out_valid <= 1'b0;
      cur_ch    <= '0;
    end else begin
      if (r_state == SCAN && mode == MODE_DIRECT) begin
        r_state <= DIRECT;
      end
`ifdef CHAN_MUX_SCAN_EN
      else if (r_state == DIRECT && en && mode == MODE_SCAN) begin
        r_state <= SCAN;
      end
`endif
      if (en) begin
        if (w_scan_active) begin
          out       <= w_ptr_data;
          cur_ch    <= w_ptr;
          out_valid <= 1'b1;
        end else begin
          out       <= w_sel_ok ? w_sel_data : '0;
          cur_ch    <= sel;
          out_valid <= w_sel_ok;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_chan_mux_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_chan_mux_seq : randomized bench with a behavioural selector model  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_chan_mux_seq;
  localparam int CH      = 6;
  localparam int W       = 4;
  localparam int DWELL_W = 8;
  localparam int SW      = 3;
`ifdef CHAN_MUX_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               en    = 1'b0;
  logic               mode  = 1'b0;
  logic [SW-1:0]      sel   = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [CH*W-1:0]    data  = '0;
  logic [W-1:0]       out;
  logic               out_valid;
  logic [SW-1:0]      cur_ch;
  logic               wrap;

  int n_vec = 0;
  int n_err = 0;

  // model: scanning flag, channel being shown, cycles already spent on it,
  // and whether the next channel-0 presentation follows a wrap
  bit       m_scan;
  int       m_ptr;
  int       m_held;
  bit       m_pend_wrap;
  logic [W-1:0] e_out;
  bit       e_valid;
  bit       e_wrap;
  int       e_cur;

  chan_mux_seq #(.CH(CH), .W(W), .DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .sel       (sel),
    .dwell     (dwell),
    .data      (data),
    .out       (out),
    .out_valid (out_valid),
    .cur_ch    (cur_ch),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] chan(input int k);
    logic [CH*W-1:0] d;
    d = data;
    return d[k*W +: W];
  endfunction

  task automatic model_reset();
    m_scan = 0; m_ptr = 0; m_held = 0; m_pend_wrap = 0;
    e_out = '0; e_valid = 0; e_wrap = 0; e_cur = 0;
  endtask

  task automatic model_edge();
    bit showing_scan;
    bit next_scan;
    showing_scan = m_scan && mode;
    next_scan    = m_scan;
    if (m_scan && !mode) next_scan = 0;
    else if (!m_scan && en && mode && SCAN_EN) next_scan = 1;
    e_wrap = 0;
    if (en) begin
      if (showing_scan) begin
        e_out = chan(m_ptr); e_cur = m_ptr; e_valid = 1; e_wrap = m_pend_wrap;
        if (m_held >= int'(dwell)) begin
          m_held = 0;
          m_pend_wrap = (m_ptr == CH - 1);
          m_ptr = (m_ptr + 1) % CH;
        end else begin
          m_held++;
          m_pend_wrap = 0;
        end
      end else begin
        e_cur = int'(sel);
        e_valid = (int'(sel) < CH);
        e_out = e_valid ? chan(int'(sel)) : '0;
      end
    end else begin
      e_valid = 0;
    end
    if (!m_scan) begin
      m_ptr = 0; m_held = 0; m_pend_wrap = 0;
    end
    m_scan = next_scan;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".out"},   32'(out),       32'(e_out));
    check({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    check({tag, ".cur"},   32'(cur_ch),    32'(e_cur));
    check({tag, ".wrap"},  32'(wrap),      32'(e_wrap));
  endtask

  task automatic cycle(input string tag);
    if (!rst_n) model_reset();
    else        model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic load_ramp();
    data = {4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
  endtask

  initial begin
    model_reset();
    load_ramp();

    for (int i = 0; i < 3; i++) begin
      en = 1'($urandom); mode = 1'($urandom); sel = SW'($urandom);
      dwell = DWELL_W'($urandom); data = (CH*W)'($urandom);
      cycle("reset");
    end
    load_ramp();
    en = 1; mode = 0;
    #2 rst_n = 1;

    for (int s = 0; s < 8; s++) begin
      sel = SW'(s);
      cycle("direct");
    end

    sel = 0; mode = 1; dwell = 0;
    for (int i = 0; i < 14; i++) cycle("scan_d0");

    mode = 0; cycle("to_direct");
    mode = 1; dwell = 2;
    for (int i = 0; i < 22; i++) cycle("scan_d2");

    for (int i = 0; i < 40 && !(e_cur == 3 && e_valid && m_scan); i++) cycle("seek3");
    en = 0;
    for (int i = 0; i < 4; i++) cycle("pause");
    en = 1;
    for (int i = 0; i < 6; i++) cycle("resume");
    mode = 0; sel = 1;
    cycle("back_direct");
    cycle("back_direct");

    mode = 1; dwell = 1; sel = 0;
    for (int i = 0; i < 40 && !(e_cur == 4 && e_valid && m_scan); i++) cycle("seek4");
    #2 rst_n = 0;
    #1;
    model_reset();
    compare_all("async_rst");
    #1 rst_n = 1;
    for (int i = 0; i < 6; i++) cycle("restart");

    for (int i = 0; i < 600; i++) begin
      en = ($urandom % 8) != 0;
      if ($urandom % 16 == 0) mode = ~mode;
      sel = SW'($urandom);
      if ($urandom % 24 == 0) dwell = DWELL_W'($urandom % 4);
      if ($urandom % 4 == 0) data = (CH*W)'($urandom);
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
